// File: rtl/sprite_line_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetch_if
// Purpose  : Host write port, run command and pixel stream of the sprite
//            pattern memory, bundled with master/slave views.
// Revision : 1.0  initial release
// ============================================================================
interface sprite_line_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 4,
  parameter int LEN_W  = 6
);
  localparam int NPIX = DATA_W / PIX_W;

  // Host write port
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [NPIX-1:0]   wr_mask_i;
  logic [DATA_W-1:0] wr_data_i;

  // Run command
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [LEN_W-1:0]  start_len_i;
  logic              hflip_i;
  logic              abort_i;
  logic              busy_o;

  // Pixel stream
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic [PIX_W-1:0]  pix_data_o;
  logic              pix_last_o;

  // Host / compositor side
  modport master (
    output wr_en_i, wr_addr_i, wr_mask_i, wr_data_i,
    output start_i, start_addr_i, start_len_i, hflip_i, abort_i,
    output pix_ready_i,
    input  busy_o, pix_valid_o, pix_data_o, pix_last_o
  );

  // Memory / streaming engine side
  modport slave (
    input  wr_en_i, wr_addr_i, wr_mask_i, wr_data_i,
    input  start_i, start_addr_i, start_len_i, hflip_i, abort_i,
    input  pix_ready_i,
    output busy_o, pix_valid_o, pix_data_o, pix_last_o
  );
endinterface
`default_nettype wire

// File: rtl/sprite_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetch
// Purpose  : Lane-split sprite pattern memory with masked host writes and a
//            run engine that streams unpacked pixels over valid/ready,
//            one pixel per clock once primed (two-word prefetch buffer).
// Revision : 1.0  initial release
// ============================================================================
module sprite_line_fetch #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 8,
  parameter int    PIX_W     = 4,
  parameter int    LEN_W     = 6,
  parameter string INIT_FILE = ""
) (
  input  wire logic          clk,
  input  wire logic          reset_n_i,
  sprite_line_fetch_if.slave bus
);

  localparam int NPIX  = DATA_W / PIX_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Element j of a buffered word is the j-th pixel in stream order
  typedef logic [NPIX-1:0][PIX_W-1:0] word_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              hflip_q, hflip_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [1:0]        count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  word_t             slot0_q, slot0_d;
  word_t             slot1_q, slot1_d;
  logic              slot0_last_q, slot0_last_d;
  logic              slot1_last_q, slot1_last_d;

  logic              rd_en;
  word_t             push_word;
  logic              pix_valid;
  logic              xfer;
  logic              pop;
  logic              can_issue;
  logic [1:0]        occupancy;

  wire [NPIX-1:0][PIX_W-1:0] rd_word;

  // --------------------------------------------------------------------------
  // One memory per pixel lane. Lane k holds the k-th pixel from the left of
  // a word. Mask bit j guards the pixel at wr_data_i[j*PIX_W +: PIX_W], so
  // the mask reads left-to-right in the same order as the pixels it covers.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NPIX; k++) begin : g_lane
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_q;

    // Masked lane write and registered read; a same-address read sees old data
    always @(posedge clk) begin
      if (bus.wr_en_i && bus.wr_mask_i[NPIX-1-k]) begin
        mem[bus.wr_addr_i] <= bus.wr_data_i[DATA_W-1-k*PIX_W -: PIX_W];
      end
      if (rd_en) begin
        rd_q <= mem[addr_q];
      end
    end

    assign rd_word[k] = rd_q;
  end

  // Stream-side handshake terms; abort suppresses any transfer
  assign pix_valid = (count_q != 2'd0);
  assign xfer      = pix_valid && bus.pix_ready_i && !bus.abort_i;
  assign pop       = xfer && (idx_q == IDX_W'(NPIX - 1));
  assign occupancy = count_q + 2'(rd_pend_q);
  assign can_issue = ((occupancy - 2'(pop)) < 2'd2);

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.pix_valid_o = pix_valid;
  assign bus.pix_data_o  = pix_valid ? slot0_q[idx_q] : '0;
  assign bus.pix_last_o  = pix_valid && slot0_last_q && (idx_q == IDX_W'(NPIX - 1));

  // Reorder a freshly read word into stream order (reversed when flipped)
  always_comb begin
    push_word = '0;
    for (int j = 0; j < NPIX; j++) begin
      push_word[j] = hflip_q ? rd_word[NPIX-1-j] : rd_word[j];
    end
  end

  // Next-state: run control, read issue, pixel index and prefetch buffer
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    left_d       = left_q;
    hflip_d      = hflip_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = rd_last_q;
    count_d      = count_q;
    idx_d        = idx_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    slot0_last_d = slot0_last_q;
    slot1_last_d = slot1_last_q;
    rd_en        = 1'b0;

    if (bus.abort_i) begin
      state_d = S_IDLE;
      count_d = 2'd0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && (bus.start_len_i != '0)) begin
            state_d = S_FETCH;
            hflip_d = bus.hflip_i;
            left_d  = bus.start_len_i;
            // A flipped run starts from its highest word
            addr_d  = bus.hflip_i
                    ? bus.start_addr_i + ADDR_W'(bus.start_len_i) - ADDR_W'(1)
                    : bus.start_addr_i;
          end
        end
        S_FETCH: begin
          // Issue only when a slot will be free for the returning word
          if (can_issue) begin
            rd_en     = 1'b1;
            rd_pend_d = 1'b1;
            rd_last_d = (left_q == LEN_W'(1));
            left_d    = left_q - LEN_W'(1);
            addr_d    = hflip_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            if (left_q == LEN_W'(1)) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && slot0_last_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (xfer) begin
        idx_d = (idx_q == IDX_W'(NPIX - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      case ({rd_pend_q, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d      = slot1_q;
            slot0_last_d = slot1_last_q;
            slot1_d      = push_word;
            slot1_last_d = rd_last_q;
          end else begin
            slot0_d      = push_word;
            slot0_last_d = rd_last_q;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d      = push_word;
            slot0_last_d = rd_last_q;
          end else begin
            slot1_d      = push_word;
            slot1_last_d = rd_last_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d      = slot1_q;
          slot0_last_d = slot1_last_q;
          count_d      = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Engine registers; reset drops any run in flight
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      left_q       <= '0;
      hflip_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      count_q      <= 2'd0;
      idx_q        <= '0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      slot0_last_q <= 1'b0;
      slot1_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      left_q       <= left_d;
      hflip_q      <= hflip_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      slot0_last_q <= slot0_last_d;
      slot1_last_q <= slot1_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_fetch
// Purpose  : Scoreboard bench for sprite_line_fetch: expected pixel runs are
//            queued at command time from a word-level memory model; a monitor
//            pops and compares on every handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_line_fetch;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 4;
  localparam int LEN_W  = 6;
  localparam int NPIX   = DATA_W / PIX_W;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic             l;
  } pix_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_line_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .LEN_W(LEN_W)) bus ();

  sprite_line_fetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .LEN_W(LEN_W), .INIT_FILE("")
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  logic [DATA_W-1:0] model_mem [1 << ADDR_W];
  pix_t              exp_q [$];
  int                checks = 0;
  int                errors = 0;
  bit                rand_ready = 1'b0;
  bit                clr_stall = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host write: model updates every mask-selected nibble of the word
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [NPIX-1:0] m,
                          input logic [DATA_W-1:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_mask_i = m;
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i = 1'b0;
    for (int j = 0; j < NPIX; j++) begin
      if (m[j]) model_mem[a][j*PIX_W +: PIX_W] = d[j*PIX_W +: PIX_W];
    end
  endtask

  // Expected run: the plain left-to-right pixel sequence over consecutive
  // words, reversed end-to-end when flipped; last flag on the final entry.
  task automatic push_run(input logic [ADDR_W-1:0] a, input int len, input bit hf);
    logic [PIX_W-1:0] seq [$];
    logic [DATA_W-1:0] w;
    pix_t p;
    for (int i = 0; i < len; i++) begin
      w = model_mem[a + ADDR_W'(i)];
      for (int k = 0; k < NPIX; k++) seq.push_back(w[DATA_W-1-k*PIX_W -: PIX_W]);
    end
    for (int i = 0; i < seq.size(); i++) begin
      p.d = hf ? seq[seq.size()-1-i] : seq[i];
      p.l = (i == seq.size() - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] a, input int len, input bit hf,
                           input bit accept);
    bus.start_i      = 1'b1;
    bus.start_addr_i = a;
    bus.start_len_i  = LEN_W'(len);
    bus.hflip_i      = hf;
    tick();
    bus.start_i = 1'b0;
    if (accept && len != 0) push_run(a, len, hf);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((bus.busy_o || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy_o || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_complete: busy=%0d pending=%0d required busy=0 pending=0",
               bus.busy_o, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // Consumer ready: held high or pseudo-random
  initial begin
    bus.pix_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stall stability and scoreboard compare on every handshake
  initial begin
    bit   stalled;
    pix_t held;
    pix_t e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (clr_stall) begin
          stalled   = 1'b0;
          clr_stall = 1'b0;
        end
        if (stalled) begin
          check_eq("stall_valid", 32'(bus.pix_valid_o), 32'd1);
          check_eq("stall_data", 32'(bus.pix_data_o), 32'(held.d));
          check_eq("stall_last", 32'(bus.pix_last_o), 32'(held.l));
        end
        if (bus.pix_valid_o && bus.pix_ready_i) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_pixel", 32'(bus.pix_data_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_eq("pix_data", 32'(bus.pix_data_o), 32'(e.d));
            check_eq("pix_last", 32'(bus.pix_last_o), 32'(e.l));
          end
        end else if (bus.pix_valid_o) begin
          stalled = 1'b1;
          held.d  = bus.pix_data_o;
          held.l  = bus.pix_last_o;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vld [11];
    logic lst [11];
    logic bsy [11];
    logic [ADDR_W-1:0] ra;
    int rl;
    bit rh;

    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_mask_i = '0; bus.wr_data_i = '0;
    bus.start_i = 1'b0; bus.start_addr_i = '0; bus.start_len_i = '0;
    bus.hflip_i = 1'b0; bus.abort_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", 32'(bus.busy_o), 32'd0);
    check_eq("reset_valid", 32'(bus.pix_valid_o), 32'd0);
    check_eq("reset_last", 32'(bus.pix_last_o), 32'd0);
    check_eq("reset_data", 32'(bus.pix_data_o), 32'd0);
    #1 reset_n = 1'b1;
    tick();

    // Define every word so the model is exact
    for (int a = 0; a < (1 << ADDR_W); a++) do_write(ADDR_W'(a), '1, DATA_W'($urandom));

    // Masked write -> 1,B,3,D
    do_write(8'h05, 4'hF, 16'h1234);
    do_write(8'h05, 4'b0101, 16'hABCD);
    start_cmd(8'h05, 1, 1'b0, 1'b1);
    wait_idle(100);

    // Throughput and latency with ready held high
    do_write(8'h10, 4'hF, 16'h0123);
    do_write(8'h11, 4'hF, 16'h4567);
    start_cmd(8'h10, 2, 1'b0, 1'b1);
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      vld[n] = bus.pix_valid_o;
      lst[n] = bus.pix_last_o;
      bsy[n] = bus.busy_o;
    end
    tick();
    check_eq("latency_e1_valid", 32'(vld[1]), 32'd0);
    check_eq("latency_e2_valid", 32'(vld[2]), 32'd1);
    for (int n = 2; n < 10; n++) check_eq("no_bubble_valid", 32'(vld[n]), 32'd1);
    check_eq("last_on_pixel7", 32'(lst[9]), 32'd1);
    check_eq("busy_at_last", 32'(bsy[9]), 32'd1);
    check_eq("busy_after_last", 32'(bsy[10]), 32'd0);
    check_eq("tp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flip across the address wrap -> 7..0
    do_write(8'hFF, 4'hF, 16'h0123);
    do_write(8'h00, 4'hF, 16'h4567);
    start_cmd(8'hFF, 2, 1'b1, 1'b1);
    wait_idle(100);

    // Backpressure over a full-length run, with an ignored start mid-run
    rand_ready = 1'b1;
    start_cmd(ADDR_W'($urandom), 63, 1'($urandom_range(0, 1)), 1'b1);
    repeat (40) tick();
    start_cmd(ADDR_W'($urandom), 5, 1'b1, 1'b0);
    wait_idle(3000);

    // Zero-length start is ignored
    start_cmd(8'h20, 0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("len0_busy", 32'(bus.busy_o), 32'd0);
    tick();

    // Abort mid-run
    start_cmd(8'h40, 20, 1'b0, 1'b1);
    repeat (12) tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    exp_q.delete();
    clr_stall = 1'b1;
    @(negedge clk);
    check_eq("abort_valid", 32'(bus.pix_valid_o), 32'd0);
    check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
    tick();
    wait_idle(50);

    // Abort wins over a simultaneous start
    bus.abort_i = 1'b1;
    start_cmd(8'h30, 5, 1'b0, 1'b0);
    bus.abort_i = 1'b0;
    @(negedge clk);
    check_eq("abort_over_start_busy", 32'(bus.busy_o), 32'd0);
    tick();

    // Asynchronous reset mid-run, then re-run the same words
    start_cmd(8'h80, 30, 1'b1, 1'b1);
    repeat (20) tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("arst_valid", 32'(bus.pix_valid_o), 32'd0);
    check_eq("arst_last", 32'(bus.pix_last_o), 32'd0);
    check_eq("arst_data", 32'(bus.pix_data_o), 32'd0);
    exp_q.delete();
    clr_stall = 1'b1;
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    start_cmd(8'h80, 30, 1'b1, 1'b1);
    wait_idle(2000);

    // Randomized runs with random masked writes between them
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        do_write(ADDR_W'($urandom), NPIX'($urandom), DATA_W'($urandom));
      end
      rand_ready = 1'($urandom_range(0, 1));
      ra = ADDR_W'($urandom);
      rl = int'($urandom_range(1, 63));
      rh = 1'($urandom_range(0, 1));
      start_cmd(ra, rl, rh, 1'b1);
      wait_idle(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
